// File: rtl/board_attack_scan_if.sv
// Board bus shared between the board producer and the attack scanner.
// Ports (signals):
//   board                  packed 8x8 board, PIECE_WIDTH bits per square
//   board_valid            start strobe, sampled by the scanner while idle
//   white_to_move          side to move, latched with the board
//   white_is_attacking     per-square map of squares attacked by white
//   black_is_attacking     per-square map of squares attacked by black
//   white_in_check         a white king stands on a black-attacked square
//   black_in_check         a black king stands on a white-attacked square
//   is_attacking_done      level, results valid
//   display_attacking_done one-cycle pulse one clock after done rises
// master drives the board side, slave is the scanner.
interface board_attack_scan_if #(
  parameter int PIECE_WIDTH = 4
);
  localparam int BOARD_WIDTH = PIECE_WIDTH * 64;

  logic [BOARD_WIDTH-1:0] board;
  logic                   board_valid;
  logic                   white_to_move;
  logic [63:0]            white_is_attacking;
  logic [63:0]            black_is_attacking;
  logic                   white_in_check;
  logic                   black_in_check;
  logic                   is_attacking_done;
  logic                   display_attacking_done;

  modport master (
    output board, board_valid, white_to_move,
    input  white_is_attacking, black_is_attacking,
    input  white_in_check, black_in_check,
    input  is_attacking_done, display_attacking_done
  );

  modport slave (
    input  board, board_valid, white_to_move,
    output white_is_attacking, black_is_attacking,
    output white_in_check, black_in_check,
    output is_attacking_done, display_attacking_done
  );
endinterface

// File: rtl/board_attack_scan.sv
// Sequential attack-map scanner. Latches a board snapshot, then visits one
// square per clock (64 cycles), ORing the attack set of the piece on that
// square into its colour's map. A final cycle derives the in-check flags and
// a further cycle emits the display pulse.
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous, active-low
//   bus    board_attack_scan_if.slave (board in, maps/flags/done out)
// Piece code: bit PIECE_WIDTH-1 = black, low 3 bits = type
//   (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 empty).
module board_attack_scan #(
  parameter int PIECE_WIDTH = 4,
  parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
  parameter int BOARD_WIDTH = PIECE_WIDTH * 64
) (
  input  logic               clk,
  input  logic               reset,
  board_attack_scan_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CHECK,
    PULSE
  } state_t;

  localparam logic [2:0] T_PAWN   = 3'd1;
  localparam logic [2:0] T_KNIGHT = 3'd2;
  localparam logic [2:0] T_BISHOP = 3'd3;
  localparam logic [2:0] T_ROOK   = 3'd4;
  localparam logic [2:0] T_QUEEN  = 3'd5;
  localparam logic [2:0] T_KING   = 3'd6;

  state_t                 state_reg, state_next;
  logic [5:0]             idx_reg, idx_next;
  logic [BOARD_WIDTH-1:0] board_reg, board_next;
  logic                   stm_reg, stm_next;
  logic [63:0]            white_map_reg, white_map_next;
  logic [63:0]            black_map_reg, black_map_next;
  logic                   white_chk_reg, white_chk_next;
  logic                   black_chk_reg, black_chk_next;
  logic                   done_reg, done_next;
  logic                   disp_reg, disp_next;

  // Side to move is kept with the snapshot for the board owner's benefit
  // but plays no part in attack computation.
  logic unused_side_to_move;
  assign unused_side_to_move = stm_reg;

  // Per-square decode of the latched board.
  logic [PIECE_WIDTH-1:0] sq_code [64];
  logic [63:0]            occ;
  logic [63:0]            white_king;
  logic [63:0]            black_king;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_sq
      localparam int ROW = gi / 8;
      localparam int COL = gi % 8;
      assign sq_code[gi]    = board_reg[ROW*SIDE_WIDTH + COL*PIECE_WIDTH +: PIECE_WIDTH];
      assign occ[gi]        = (sq_code[gi][2:0] != 3'd0) && (sq_code[gi][2:0] != 3'd7);
      assign white_king[gi] = !sq_code[gi][PIECE_WIDTH-1] && (sq_code[gi][2:0] == T_KING);
      assign black_king[gi] = sq_code[gi][PIECE_WIDTH-1] && (sq_code[gi][2:0] == T_KING);
    end
  endgenerate

  // Square currently under examination.
  logic [PIECE_WIDTH-1:0] cur_code;
  logic [2:0]             cur_type;
  logic                   cur_black;
  int                     cur_row;
  int                     cur_col;

  always_comb begin
    cur_code  = sq_code[idx_reg];
    cur_type  = cur_code[2:0];
    cur_black = cur_code[PIECE_WIDTH-1];
    cur_row   = 32'(idx_reg[5:3]);
    cur_col   = 32'(idx_reg[2:0]);
  end

  // Sliding rays from the current square. Directions 0..3 are orthogonal
  // (N, S, E, W), 4..7 diagonal (NE, NW, SE, SW). A ray includes the first
  // occupied square it meets and stops there; leaving the board also stops it,
  // which is what prevents wrapping between files.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ray
      localparam int DR = (gi == 0) ? 1 : (gi == 1) ? -1 : (gi < 4) ? 0 :
                          (gi < 6) ? 1 : -1;
      localparam int DC = (gi < 2) ? 0 : (gi == 2) ? 1 : (gi == 3) ? -1 :
                          (gi == 4 || gi == 6) ? 1 : -1;
      logic [63:0] mask;

      always_comb begin
        int   rr;
        int   cc;
        logic stop;
        mask = '0;
        stop = 1'b0;
        rr   = 0;
        cc   = 0;
        for (int k = 1; k < 8; k++) begin
          rr = cur_row + k * DR;
          cc = cur_col + k * DC;
          if (!stop) begin
            if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              stop = 1'b1;
            end else begin
              mask[6'(rr*8 + cc)] = 1'b1;
              if (occ[6'(rr*8 + cc)]) stop = 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  logic [63:0] orth_rays;
  logic [63:0] diag_rays;
  assign orth_rays = g_ray[0].mask | g_ray[1].mask | g_ray[2].mask | g_ray[3].mask;
  assign diag_rays = g_ray[4].mask | g_ray[5].mask | g_ray[6].mask | g_ray[7].mask;

  // Single-square hop, clipped to the board.
  function automatic logic [63:0] hop(input int r, input int c, input int dr, input int dc);
    int rr;
    int cc;
    rr  = r + dr;
    cc  = c + dc;
    hop = '0;
    if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) hop[6'(rr*8 + cc)] = 1'b1;
  endfunction

  logic [63:0] attack;

  always_comb begin
    int pawn_dr;
    attack  = '0;
    pawn_dr = cur_black ? -1 : 1;
    case (cur_type)
      T_PAWN: begin
        attack = hop(cur_row, cur_col, pawn_dr, -1) | hop(cur_row, cur_col, pawn_dr, 1);
      end
      T_KNIGHT: begin
        attack = hop(cur_row, cur_col,  2,  1) | hop(cur_row, cur_col,  2, -1) |
                 hop(cur_row, cur_col, -2,  1) | hop(cur_row, cur_col, -2, -1) |
                 hop(cur_row, cur_col,  1,  2) | hop(cur_row, cur_col,  1, -2) |
                 hop(cur_row, cur_col, -1,  2) | hop(cur_row, cur_col, -1, -2);
      end
      T_BISHOP: attack = diag_rays;
      T_ROOK:   attack = orth_rays;
      T_QUEEN:  attack = diag_rays | orth_rays;
      T_KING: begin
        attack = hop(cur_row, cur_col,  1,  0) | hop(cur_row, cur_col, -1,  0) |
                 hop(cur_row, cur_col,  0,  1) | hop(cur_row, cur_col,  0, -1) |
                 hop(cur_row, cur_col,  1,  1) | hop(cur_row, cur_col,  1, -1) |
                 hop(cur_row, cur_col, -1,  1) | hop(cur_row, cur_col, -1, -1);
      end
      default: attack = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    board_next     = board_reg;
    stm_next       = stm_reg;
    white_map_next = white_map_reg;
    black_map_next = black_map_reg;
    white_chk_next = white_chk_reg;
    black_chk_next = black_chk_reg;
    done_next      = done_reg;
    disp_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.board_valid) begin
          board_next     = bus.board;
          stm_next       = bus.white_to_move;
          white_map_next = '0;
          black_map_next = '0;
          white_chk_next = 1'b0;
          black_chk_next = 1'b0;
          done_next      = 1'b0;
          idx_next       = 6'd0;
          state_next     = SCAN;
        end
      end
      SCAN: begin
        // attack is zero for empty squares, so no occupancy gate needed.
        if (cur_black) black_map_next = black_map_reg | attack;
        else           white_map_next = white_map_reg | attack;
        idx_next = idx_reg + 6'd1;
        if (idx_reg == 6'd63) state_next = CHECK;
      end
      CHECK: begin
        white_chk_next = |(white_king & black_map_reg);
        black_chk_next = |(black_king & white_map_reg);
        done_next      = 1'b1;
        state_next     = PULSE;
      end
      PULSE: begin
        disp_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      idx_reg       <= 6'd0;
      board_reg     <= '0;
      stm_reg       <= 1'b0;
      white_map_reg <= '0;
      black_map_reg <= '0;
      white_chk_reg <= 1'b0;
      black_chk_reg <= 1'b0;
      done_reg      <= 1'b0;
      disp_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      board_reg     <= board_next;
      stm_reg       <= stm_next;
      white_map_reg <= white_map_next;
      black_map_reg <= black_map_next;
      white_chk_reg <= white_chk_next;
      black_chk_reg <= black_chk_next;
      done_reg      <= done_next;
      disp_reg      <= disp_next;
    end
  end

  assign bus.white_is_attacking     = white_map_reg;
  assign bus.black_is_attacking     = black_map_reg;
  assign bus.white_in_check         = white_chk_reg;
  assign bus.black_in_check         = black_chk_reg;
  assign bus.is_attacking_done      = done_reg;
  assign bus.display_attacking_done = disp_reg;

endmodule

// File: tb/tb_board_attack_scan.sv
// Randomised and directed bench for board_attack_scan with a behavioural
// attack-map model built from piece movement rules on an 8x8 grid.
module tb_board_attack_scan;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  board_attack_scan_if #(.PIECE_WIDTH(4)) bus ();

  board_attack_scan dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ray/step directions: 0..3 orthogonal, 4..7 diagonal.
  localparam int DIR_DR [8] = '{1, -1, 0, 0, 1, 1, -1, -1};
  localparam int DIR_DC [8] = '{0, 0, 1, -1, 1, -1, 1, -1};
  localparam int KN_DR  [8] = '{2, 2, -2, -2, 1, 1, -1, -1};
  localparam int KN_DC  [8] = '{1, -1, 1, -1, 2, -2, 2, -2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit on_board(input int r, input int c);
    return (r >= 0 && r < 8 && c >= 0 && c < 8);
  endfunction

  function automatic bit occupied(input logic [255:0] b, input int r, input int c);
    logic [3:0] p;
    p = b[(r*8+c)*4 +: 4];
    return (p[2:0] != 3'd0 && p[2:0] != 3'd7);
  endfunction

  function automatic void model(input logic [255:0] b,
                                output logic [63:0] wm, output logic [63:0] bm,
                                output logic wc, output logic bc);
    logic [3:0]  p;
    logic [63:0] a;
    int t, r, c, nr, nc, lo, hi;
    wm = '0; bm = '0; wc = 1'b0; bc = 1'b0;
    for (int s = 0; s < 64; s++) begin
      p = b[s*4 +: 4];
      t = int'(p[2:0]);
      r = s / 8;
      c = s % 8;
      a = '0;
      if (t == 1) begin
        nr = p[3] ? r - 1 : r + 1;
        if (on_board(nr, c - 1)) a[nr*8 + c - 1] = 1'b1;
        if (on_board(nr, c + 1)) a[nr*8 + c + 1] = 1'b1;
      end else if (t == 2) begin
        for (int d = 0; d < 8; d++)
          if (on_board(r + KN_DR[d], c + KN_DC[d])) a[(r + KN_DR[d])*8 + c + KN_DC[d]] = 1'b1;
      end else if (t == 6) begin
        for (int d = 0; d < 8; d++)
          if (on_board(r + DIR_DR[d], c + DIR_DC[d])) a[(r + DIR_DR[d])*8 + c + DIR_DC[d]] = 1'b1;
      end else if (t >= 3 && t <= 5) begin
        lo = (t == 3) ? 4 : 0;
        hi = (t == 4) ? 3 : 7;
        for (int d = lo; d <= hi; d++) begin
          nr = r + DIR_DR[d];
          nc = c + DIR_DC[d];
          while (on_board(nr, nc)) begin
            a[nr*8 + nc] = 1'b1;
            if (occupied(b, nr, nc)) break;
            nr += DIR_DR[d];
            nc += DIR_DC[d];
          end
        end
      end
      if (p[3]) bm |= a;
      else      wm |= a;
    end
    for (int s = 0; s < 64; s++) begin
      p = b[s*4 +: 4];
      if (p == 4'h6 && bm[s]) wc = 1'b1;
      if (p == 4'hE && wm[s]) bc = 1'b1;
    end
  endfunction

  function automatic logic [255:0] garbage();
    logic [255:0] g;
    for (int i = 0; i < 8; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    b = '0;
    for (int s = 0; s < 64; s++)
      if ($urandom_range(0, 9) < 3) b[s*4 +: 4] = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) b[$urandom_range(0, 63)*4 +: 4] = 4'h6;
    if ($urandom_range(0, 1) == 1) b[$urandom_range(0, 63)*4 +: 4] = 4'hE;
    return b;
  endfunction

  // One scan transaction; optional second strobe with bd2 at scan cycle inject_at.
  task automatic run_board(input logic [255:0] bd, input int inject_at,
                           input logic [255:0] bd2, input string tag);
    logic [63:0] ewm, ebm;
    logic        ewc, ebc;
    int          cyc;
    bit          seen;
    model(bd, ewm, ebm, ewc, ebc);
    @(negedge clk);
    bus.board         = bd;
    bus.board_valid   = 1'b1;
    bus.white_to_move = 1'($urandom);
    @(posedge clk);
    #1;
    bus.board_valid = 1'b0;
    bus.board       = garbage();
    check({tag, "_done_clr"}, 64'(bus.is_attacking_done), 64'd0);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == inject_at) begin
        bus.board       = bd2;
        bus.board_valid = 1'b1;
      end else if (cyc == inject_at + 1) begin
        bus.board_valid = 1'b0;
      end
      if (bus.is_attacking_done) seen = 1'b1;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd65);
    check({tag, "_disp_early"}, 64'(bus.display_attacking_done), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_disp_pulse"}, 64'(bus.display_attacking_done), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_disp_end"}, 64'(bus.display_attacking_done), 64'd0);
    check({tag, "_done_hold"}, 64'(bus.is_attacking_done), 64'd1);
    check({tag, "_wmap"}, bus.white_is_attacking, ewm);
    check({tag, "_bmap"}, bus.black_is_attacking, ebm);
    check({tag, "_wchk"}, 64'(bus.white_in_check), 64'(ewc));
    check({tag, "_bchk"}, 64'(bus.black_in_check), 64'(ebc));
    $display("%s: done after %0d cycles wmap=%h bmap=%h wchk=%0d bchk=%0d",
             tag, cyc, bus.white_is_attacking, bus.black_is_attacking,
             bus.white_in_check, bus.black_in_check);
  endtask

  logic [255:0] bd;
  logic [255:0] bd_b;
  logic [255:0] opening;

  initial begin
    n_checks          = 0;
    n_pass            = 0;
    reset             = 1'b0;
    bus.board         = '0;
    bus.board_valid   = 1'b0;
    bus.white_to_move = 1'b0;
    #1;
    check("rst_wmap", bus.white_is_attacking, 64'd0);
    check("rst_bmap", bus.black_is_attacking, 64'd0);
    check("rst_flags", 64'({bus.white_in_check, bus.black_in_check,
                            bus.is_attacking_done, bus.display_attacking_done}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Opening position with d4 / d5 played.
    opening = '0;
    for (int c = 0; c < 8; c++) begin
      opening[(8 + c)*4 +: 4]  = 4'h1;
      opening[(48 + c)*4 +: 4] = 4'h9;
    end
    for (int c = 0; c < 8; c++) begin
      logic [31:0] back;
      back = 32'h42365324;  // a..h: R N B Q K B N R, nibble 0 = file a
      opening[c*4 +: 4]        = back[c*4 +: 4];
      opening[(56 + c)*4 +: 4] = back[c*4 +: 4] | 4'h8;
    end
    opening[11*4 +: 4] = 4'h0;
    opening[27*4 +: 4] = 4'h1;
    opening[51*4 +: 4] = 4'h0;
    opening[35*4 +: 4] = 4'h9;
    run_board(opening, -1, '0, "opening");
    check("open_w_rank3", bus.white_is_attacking & 64'h0000_0000_00FF_0000, 64'h0000_0000_00FF_0000);
    check("open_w_d4", bus.white_is_attacking & 64'h0000_0014_0000_0000, 64'h0000_0014_0000_0000);
    check("open_b_rank6", bus.black_is_attacking & 64'h0000_FF00_0000_0000, 64'h0000_FF00_0000_0000);
    check("open_b_d5", bus.black_is_attacking & 64'h0000_0000_1400_0000, 64'h0000_0000_1400_0000);

    // Rook a1 gives check to king a8.
    bd = '0;
    bd[0*4 +: 4]  = 4'h4;
    bd[56*4 +: 4] = 4'hE;
    run_board(bd, -1, '0, "rook_king");
    check("rk_wmap", bus.white_is_attacking, 64'h0101_0101_0101_01FE);
    check("rk_bmap", bus.black_is_attacking, 64'h0203_0000_0000_0000);
    check("rk_bchk", 64'(bus.black_in_check), 64'd1);

    // Black pawn a5 blocks the rook ray.
    bd[32*4 +: 4] = 4'h9;
    run_board(bd, -1, '0, "rook_blocked");
    check("rb_wmap", bus.white_is_attacking, 64'h0000_0001_0101_01FE);
    check("rb_bmap", bus.black_is_attacking, 64'h0203_0000_0200_0000);
    check("rb_bchk", 64'(bus.black_in_check), 64'd0);

    // Lone knights in the corners.
    bd = '0;
    bd[0*4 +: 4] = 4'h2;
    run_board(bd, -1, '0, "knight_a1");
    check("na1_wmap", bus.white_is_attacking, 64'h0000_0000_0002_0400);
    bd = '0;
    bd[63*4 +: 4] = 4'h2;
    run_board(bd, -1, '0, "knight_h8");
    check("nh8_wmap", bus.white_is_attacking, 64'h0020_4000_0000_0000);

    // Reset asserted mid-scan aborts without any done.
    begin
      bit seen_done;
      @(negedge clk);
      bus.board       = opening;
      bus.board_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.board_valid = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_wmap", bus.white_is_attacking, 64'd0);
      check("midrst_bmap", bus.black_is_attacking, 64'd0);
      check("midrst_flags", 64'({bus.white_in_check, bus.black_in_check,
                                 bus.is_attacking_done, bus.display_attacking_done}), 64'd0);
      repeat (2) @(negedge clk);
      reset     = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk);
        #1;
        if (bus.is_attacking_done || bus.display_attacking_done) seen_done = 1'b1;
      end
      check("midrst_no_done", 64'(seen_done), 64'd0);
      $display("mid_scan_reset: outputs cleared, no completion observed=%0d", seen_done);
    end
    run_board(opening, -1, '0, "after_reset");

    // A second strobe during the scan is ignored.
    bd   = rand_board();
    bd_b = rand_board();
    run_board(bd, 10, bd_b, "ignored_strobe");

    // Random boards.
    for (int n = 0; n < 24; n++) begin
      bd = rand_board();
      run_board(bd, -1, '0, $sformatf("random_%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/board_attack_scan.md
Name: board_attack_scan

Overview:
- Computes per-square attack maps for both colours from a packed 8x8 board snapshot.
- Derives the white and black in-check flags from those maps.
- Sits beside the move generator. It consumes the same board bus and board_valid strobe, and its results are used for check and legality decisions.
- Uses a sequential scan of one square per clock to keep area modest.

Parameters:
- PIECE_WIDTH, 4, bits per square.
- SIDE_WIDTH, PIECE_WIDTH*8, bits per rank.
- BOARD_WIDTH, PIECE_WIDTH*64, bits per board.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- board  in  BOARD_WIDTH  square s=row*8+col at board[s*PIECE_WIDTH +: PIECE_WIDTH]. Row 0 is white's back rank; col 0 is file a.
- board_valid  in  1  start strobe; board is sampled when this is high in IDLE.
- white_to_move  in  1  side to move; latched with board; does not affect any output.
- white_is_attacking  out  64  bit s set if any white piece attacks square s.
- black_is_attacking  out  64  same, for black pieces.
- white_in_check  out  1  a white king stands on a square in black_is_attacking.
- black_in_check  out  1  a black king stands on a square in white_is_attacking.
- is_attacking_done  out  1  level; results valid.
- display_attacking_done  out  1  one-cycle pulse one clock after is_attacking_done rises.

Behaviour:
- Piece encoding:
  - bit PIECE_WIDTH-1 = 1 means black.
  - Low 3 bits give the type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; 7 is treated as empty.
- Reset (async, low):
  - state=IDLE.
  - Both maps 0, both check flags 0, is_attacking_done 0, display_attacking_done 0.
  - Index 0, latched board all-empty.
  - Reset mid-scan aborts immediately; no done is produced.
- IDLE:
  - On board_valid=1: latch board and white_to_move, clear both maps and both check flags, clear is_attacking_done, index<=0, go SCAN.
- SCAN:
  - Each cycle, examine latched square[index] and OR its attack set into the map of its colour. Empty squares add nothing.
  - index increments; after index 63 is processed, go CHECK.
  - Exactly 64 SCAN cycles.
- Attack sets (edge-clipped, no wrap between files):
  - White pawn at (r,c): (r+1,c±1). Black pawn at (r,c): (r-1,c±1). No forward squares, no en passant.
  - Knight: 8 L-jumps.
  - King: 8 adjacent squares.
  - Bishop, rook and queen: rays along diagonals, orthogonals, or both. Each ray includes successive squares up to and including the first occupied square, then stops.
  - Attacked squares include squares holding own pieces (defended squares).
  - Ray evaluation is combinational on the latched board, max 7 steps per ray.
- CHECK (1 cycle):
  - white_in_check <= OR over squares holding a white king of black_is_attacking[s]; black symmetric.
  - No king of a colour gives a check flag of 0.
  - is_attacking_done <= 1; go PULSE.
- PULSE:
  - display_attacking_done <= 1 for exactly one cycle; go IDLE.
- Latency: board_valid sampled at edge E0, is_attacking_done rises at E65, display_attacking_done is high for the cycle after E66.
- Outputs hold until the next accepted board_valid.
- board_valid while not in IDLE is ignored.
- Changes on board after sampling have no effect.

Test Plan:
- Standard opening with white pawn d2→d4 and black pawn d7→d5, board_valid pulse:
  - is_attacking_done at +65 cycles.
  - white_is_attacking bits 16..23 all set, and bits 34 and 36 set.
  - black_is_attacking bits 40..47 all set, and bits 26 and 28 set.
  - Both check flags 0.
- Empty board, white rook a1 (s0), black king a8 (s56):
  - white_is_attacking = bits 1..7 and 8,16,24,32,40,48,56 set.
  - black_in_check=1, white_in_check=0.
  - black_is_attacking = bits 48,49,57.
- Same as above plus black pawn a5 (s32):
  - White rook ray stops at bit 32; bits 40,48,56 are clear.
  - black_in_check=0.
  - black_is_attacking includes bit 25 (pawn attack b4).
- Lone white knight a1:
  - white_is_attacking = 64'h0000_0000_0002_0400, checks 0.
  - Repeat with knight h8: bits 46 and 53 only.
- Reset asserted low at scan cycle 30:
  - All outputs 0 immediately; no done pulse.
  - After release, a new board_valid gives correct results at +65.
- Second board_valid at scan cycle 10: ignored, results reflect the first board, done at +65 from the first strobe.
